axis_uart_framer: RTL and testbench
===================================

Name: axis_uart_framer

Overview:
- Transmit-direction counterpart of the UART-receive framer.
- Accepts 8-bit AXI-Stream beats from the switch. Serialises each beat to the UART transmitter as two bytes: a command byte carrying TLAST, then the data byte.
- The receive-side framer on the far end reconstructs the beat and its TLAST from this byte pair.
- Also counts completed packets for status/debug.

Parameters:
- CMD_LAST, 8'h01, command byte sent when the beat has tlast=1.
- CMD_MORE, 8'h00, command byte sent when the beat has tlast=0.
- PKT_CNT_W, 16, width of the packet counter output.

Ports:
- clk  input  1  clock; all logic is posedge.
- rst  input  1  reset, synchronous, active-low.
- s_axis_tvalid  input  1  beat valid from switch.
- s_axis_tready  output  1  block ready to take a beat.
- s_axis_tdata  input  8  beat data.
- s_axis_tlast  input  1  last beat of packet.
- uart_tx_valid  output  1  byte valid to UART transmitter.
- uart_tx_ready  input  1  UART transmitter can accept a byte this cycle.
- uart_tx_data  output  8  byte to UART transmitter.
- pkt_count  output  PKT_CNT_W  number of packets fully sent (wraps).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; held data=0; held last=0; pkt_count=0.
  - Outputs after reset: uart_tx_valid=0, uart_tx_data=0, s_axis_tready=1, busy=0.
- Derived outputs:
  - s_axis_tready = (state==IDLE), decoded from the state register only.
  - busy = (state!=IDLE).
  - uart_tx_valid = (state==SEND_CMD or SEND_DATA).
  - No combinational path from any input to any output.
- uart_tx_data by state:
  - SEND_CMD: CMD_LAST if held last==1, else CMD_MORE.
  - SEND_DATA: held data byte.
  - IDLE: last value, don't-care to the consumer.
- IDLE:
  - On s_axis_tvalid && s_axis_tready: capture tdata and tlast into holding registers; next state SEND_CMD.
  - Otherwise stay in IDLE.
- SEND_CMD:
  - uart_tx_valid=1.
  - On uart_tx_ready: next state SEND_DATA.
  - Otherwise hold; uart_tx_data stays stable.
- SEND_DATA:
  - uart_tx_valid=1.
  - On uart_tx_ready: next state IDLE; if held last==1, pkt_count <= pkt_count+1 (modulo 2^PKT_CNT_W, wraps from all-ones to 0).
  - Otherwise hold.
- Handshake rules:
  - A UART byte transfers on a cycle with uart_tx_valid && uart_tx_ready.
  - Once valid is raised, it never drops and uart_tx_data never changes until that transfer.
  - The holding registers are written only on the AXIS handshake, so a changing s_axis_tdata while busy has no effect.
- Latency and throughput:
  - AXIS handshake in cycle N -> command byte valid in N+1.
  - With uart_tx_ready held at 1: data byte in N+2, s_axis_tready high again in N+3.
  - Maximum rate is one beat per 3 cycles.
- uart_tx_ready while in IDLE is ignored; no byte is issued.
- tlast on a single-beat packet: CMD_LAST then data; pkt_count increments.
- Reset mid-operation (SEND_CMD or SEND_DATA): the beat in flight is dropped, uart_tx_valid drops in the next cycle, and pkt_count clears. No partial-pair recovery.

Test Plan:
- Reset, then beat tdata=8'hA5 tlast=0 with uart_tx_ready=1 -> UART bytes 8'h00, 8'hA5 on consecutive cycles; tready low for exactly 2 cycles after the handshake; pkt_count stays 0.
- 3-beat packet 8'h11, 8'h22, 8'h33 (tlast on 8'h33) -> byte sequence 00,11,00,22,01,33; pkt_count=1 after the last data byte transfers.
- Backpressure: uart_tx_ready low for 5 cycles during SEND_CMD, then during SEND_DATA for beat 8'h5C tlast=1 -> uart_tx_valid stays 1 and data stays 8'h01, then 8'h5C, with no duplication; s_axis_tready=0 throughout.
- Input churn: s_axis_tdata toggles while busy and s_axis_tvalid is held -> only the captured value is sent; the next beat is accepted only when the block returns to IDLE.
- Reset asserted in SEND_DATA with pkt_count=3 -> next cycle uart_tx_valid=0, s_axis_tready=1, pkt_count=0.
- Wrap with PKT_CNT_W=2: send 5 single-beat packets -> pkt_count goes 1,2,3,0,1.

Source files
------------

// File: rtl/axis_uart_framer.sv
// AXI-Stream to UART transmit framer: each 8-bit beat leaves as a command byte
// (carrying TLAST) followed by the data byte, and completed packets are counted.
module axis_uart_framer #(
    parameter logic [7:0] CMD_LAST  = 8'h01,
    parameter logic [7:0] CMD_MORE  = 8'h00,
    parameter int         PKT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 uart_tx_valid,
    input  logic                 uart_tx_ready,
    output logic [7:0]           uart_tx_data,
    output logic [PKT_CNT_W-1:0] pkt_count,
    output logic                 busy
);

    // Handshakes: a beat is taken when s_axis_tvalid && s_axis_tready, a byte
    // leaves when uart_tx_valid && uart_tx_ready; once raised, uart_tx_valid and
    // uart_tx_data hold until that byte transfers.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_CMD  = 2'd1,
        SEND_DATA = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [7:0]           held_data;
    logic                 held_last;
    logic [PKT_CNT_W-1:0] pkt_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            held_data   <= 8'h00;
            held_last   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && s_axis_tvalid) begin
                held_data <= s_axis_tdata;
                held_last <= s_axis_tlast;
            end
            if (state == SEND_DATA && uart_tx_ready && held_last) begin
                pkt_count_q <= pkt_count_q + PKT_CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (s_axis_tvalid) state_next = SEND_CMD;
            SEND_CMD:  if (uart_tx_ready) state_next = SEND_DATA;
            SEND_DATA: if (uart_tx_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Every output decodes registers only, so no input reaches an output combinationally.
    assign s_axis_tready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign uart_tx_valid = (state == SEND_CMD) || (state == SEND_DATA);
    assign uart_tx_data  = (state == SEND_CMD) ? (held_last ? CMD_LAST : CMD_MORE) : held_data;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_uart_framer.sv
// Directed bench for axis_uart_framer: a 16-bit-counter instance plus a 2-bit-counter
// instance driven by the same stimulus, with transferred bytes compared to a queue.
module tb_axis_uart_framer;

    logic       clk;
    logic       rst;
    logic       s_axis_tvalid;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tlast;
    logic       uart_tx_ready;

    logic        s_axis_tready;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic [15:0] pkt_count;
    logic        busy;

    logic        w_tready;
    logic        w_valid;
    logic [7:0]  w_data;
    logic [1:0]  w_count;
    logic        w_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    axis_uart_framer dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_tx_data(uart_tx_data), .pkt_count(pkt_count), .busy(busy)
    );

    axis_uart_framer #(.PKT_CNT_W(2)) dut_w (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(w_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .uart_tx_valid(w_valid), .uart_tx_ready(uart_tx_ready),
        .uart_tx_data(w_data), .pkt_count(w_count), .busy(w_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // byte monitor: record every UART transfer out of the main instance
    always @(posedge clk) begin
        if (rst && uart_tx_valid && uart_tx_ready) got_q.push_back(uart_tx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a beat, wait (bounded) for acceptance, then drop tvalid.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        n = 0;
        while (!s_axis_tready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'd1, 32'd0);
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!s_axis_tready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // scoreboard: compare recorded bytes with the expected queue, then empty both
    task automatic chk_bytes(input string tag);
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
        uart_tx_ready = 1'b1;
        step(); step();
        rst = 1'b1;

        // reset state; tx_ready high in IDLE must not produce bytes
        chk("rst_tready", 32'(s_axis_tready), 32'd1);
        chk("rst_valid", 32'(uart_tx_valid), 32'd0);
        chk("rst_data", 32'(uart_tx_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(pkt_count), 32'd0);
        step(); step();
        chk_bytes("idle_ready");

        // single beat, A5 tlast=0
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5; s_axis_tlast = 1'b0;
        step();
        s_axis_tvalid = 1'b0;
        chk("t1_cmd_valid", 32'(uart_tx_valid), 32'd1);
        chk("t1_cmd_data", 32'(uart_tx_data), 32'h00);
        chk("t1_tready_n1", 32'(s_axis_tready), 32'd0);
        step();
        chk("t1_dat_data", 32'(uart_tx_data), 32'hA5);
        chk("t1_tready_n2", 32'(s_axis_tready), 32'd0);
        step();
        chk("t1_tready_n3", 32'(s_axis_tready), 32'd1);
        chk("t1_valid_n3", 32'(uart_tx_valid), 32'd0);
        exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
        chk_bytes("t1");
        chk("t1_count", 32'(pkt_count), 32'd0);

        // three-beat packet
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b1);
        wait_idle();
        exp_q = '{8'h00, 8'h11, 8'h00, 8'h22, 8'h01, 8'h33};
        chk_bytes("t2");
        chk("t2_count", 32'(pkt_count), 32'd1);

        // backpressure in both send states
        uart_tx_ready = 1'b0;
        send_beat(8'h5C, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_cmd_valid", 32'(uart_tx_valid), 32'd1);
            chk("t3_cmd_data", 32'(uart_tx_data), 32'h01);
            chk("t3_cmd_tready", 32'(s_axis_tready), 32'd0);
            step();
        end
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_dat_valid", 32'(uart_tx_valid), 32'd1);
            chk("t3_dat_data", 32'(uart_tx_data), 32'h5C);
            chk("t3_dat_tready", 32'(s_axis_tready), 32'd0);
            step();
        end
        uart_tx_ready = 1'b1;
        step();
        chk("t3_tready_back", 32'(s_axis_tready), 32'd1);
        exp_q = '{8'h01, 8'h5C};
        chk_bytes("t3");
        chk("t3_count", 32'(pkt_count), 32'd2);

        // input churn while busy with tvalid held
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77; s_axis_tlast = 1'b1;
        step();
        s_axis_tdata = 8'h88; s_axis_tlast = 1'b0;
        chk("t4_tready_busy", 32'(s_axis_tready), 32'd0);
        chk("t4_cmd_data", 32'(uart_tx_data), 32'h01);
        step();
        s_axis_tdata = 8'h99;
        chk("t4_dat_data", 32'(uart_tx_data), 32'h77);
        step();
        chk("t4_tready_idle", 32'(s_axis_tready), 32'd1);
        chk("t4_count", 32'(pkt_count), 32'd3);
        step();
        s_axis_tvalid = 1'b0;
        chk("t4_next_cmd", 32'(uart_tx_data), 32'h00);
        step();
        chk("t4_next_dat", 32'(uart_tx_data), 32'h99);
        step();
        exp_q = '{8'h01, 8'h77, 8'h00, 8'h99};
        chk_bytes("t4");
        chk("t4_count_after", 32'(pkt_count), 32'd3);

        // reset while in SEND_DATA
        send_beat(8'hE1, 1'b1);
        step();
        chk("t5_in_data", 32'(uart_tx_data), 32'hE1);
        chk("t5_wcount_pre", 32'(w_count), 32'd3);
        uart_tx_ready = 1'b0;
        rst = 1'b0;
        step();
        chk("t5_valid", 32'(uart_tx_valid), 32'd0);
        chk("t5_tready", 32'(s_axis_tready), 32'd1);
        chk("t5_count", 32'(pkt_count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        uart_tx_ready = 1'b1;
        exp_q = '{8'h01};
        chk_bytes("t5");

        // narrow counter wraps: 1,2,3,0,1
        for (int i = 1; i <= 5; i++) begin
            send_beat(8'(8'h40 + i), 1'b1);
            wait_idle();
            chk("t6_count", 32'(pkt_count), 32'(i));
            chk("t6_wcount", 32'(w_count), 32'(i % 4));
            exp_q.push_back(8'h01);
            exp_q.push_back(8'(8'h40 + i));
        end
        chk_bytes("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
